// File: rtl/aemb_bus_pkg.sv
// Shared types and constants for the AEMB execute-stage bus transaction unit.
package aemb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DWB  = 2'd1,
    FSL  = 2'd2,
    DONE = 2'd3
  } busState_t;

  // Transfer size codes; code 3 behaves as a word.
  localparam logic [1:0] SIZ_BYTE = 2'd0;
  localparam logic [1:0] SIZ_HALF = 2'd1;
  localparam logic [1:0] SIZ_WORD = 2'd2;

  // Big-endian byte selects: bit 3 is byte 0 (bits 31:24 of the data word).
  localparam logic [3:0] SEL_BYTE0   = 4'b1000;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

  // Byte-select pattern for a given size and address offset.
  function automatic logic [3:0] sizeSel(input logic [1:0] siz, input logic [1:0] adrLo);
    logic [3:0] sel;
    case (siz)
      SIZ_BYTE: sel = SEL_BYTE0 >> adrLo;
      SIZ_HALF: sel = adrLo[1] ? SEL_HALF_LO : SEL_HALF_HI;
      default:  sel = SEL_WORD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/aemb_bus_align.sv
// Combinational lane handling: byte selects and store replication for the
// incoming request, and lane extraction with zero-extension for load data.
module aemb_bus_align
  import aemb_bus_pkg::*;
(
  input  logic [1:0]  reqSiz,
  input  logic [1:0]  reqAdrLo,
  input  logic [31:0] reqDat,
  output logic [3:0]  reqSel,
  output logic [31:0] reqDatRep,
  input  logic [1:0]  lodSiz,
  input  logic [1:0]  lodAdrLo,
  input  logic [31:0] lodDat,
  output logic [31:0] lodExt
);

  // Request side: selects follow size/offset, store data copied to every lane.
  always_comb begin
    reqSel    = sizeSel(reqSiz, reqAdrLo);
    reqDatRep = reqDat;
    case (reqSiz)
      SIZ_BYTE: reqDatRep = {4{reqDat[7:0]}};
      SIZ_HALF: reqDatRep = {2{reqDat[15:0]}};
      default:  reqDatRep = reqDat;
    endcase
  end

  // Load side: pick the addressed lane and zero-extend it.
  always_comb begin
    lodExt = lodDat;
    case (lodSiz)
      SIZ_BYTE: begin
        case (lodAdrLo)
          2'd0:    lodExt = {24'd0, lodDat[31:24]};
          2'd1:    lodExt = {24'd0, lodDat[23:16]};
          2'd2:    lodExt = {24'd0, lodDat[15:8]};
          default: lodExt = {24'd0, lodDat[7:0]};
        endcase
      end
      SIZ_HALF: lodExt = lodAdrLo[1] ? {16'd0, lodDat[15:0]} : {16'd0, lodDat[31:16]};
      default:  lodExt = lodDat;
    endcase
  end

endmodule

// File: rtl/aemb_xbus_ctrl.sv
// Execute-stage bus transaction unit: DWB load/store and FSL get/put with
// non-blocking timeout, registered read return and pipeline stall.
module aemb_xbus_ctrl
  import aemb_bus_pkg::*;
#(
  parameter int DAW  = 32,
  parameter int FSLN = 4,
  parameter int TOUT = 4,
  localparam int CHW = $clog2(FSLN)
) (
  input  logic           gclk,
  input  logic           grst,
  input  logic           req_vld,
  input  logic           req_lod,
  input  logic           req_str,
  input  logic           req_get,
  input  logic           req_put,
  input  logic           req_nblk,
  input  logic [CHW-1:0] req_fid,
  input  logic [1:0]     req_siz,
  input  logic [DAW-1:0] req_adr,
  input  logic [31:0]    req_dat,
  output logic           dwb_stb_o,
  output logic           dwb_wre_o,
  output logic [3:0]     dwb_sel_o,
  output logic [DAW-1:0] dwb_adr_o,
  output logic [31:0]    dwb_dat_o,
  input  logic           dwb_ack_i,
  input  logic [31:0]    dwb_dat_i,
  output logic           fsl_stb_o,
  output logic           fsl_wre_o,
  output logic [CHW-1:0] fsl_tag_o,
  output logic [31:0]    fsl_dat_o,
  input  logic           fsl_ack_i,
  input  logic [31:0]    fsl_dat_i,
  output logic           bus_stall,
  output logic           rd_vld,
  output logic [31:0]    rd_dat,
  output logic           nblk_fail
);

  busState_t      state, stateNext;
  logic [DAW-1:0] adrReg;
  logic [1:0]     adrLoReg;
  logic [1:0]     sizReg;
  logic [3:0]     selReg;
  logic [31:0]    datReg;
  logic [CHW-1:0] fidReg;
  logic           wreReg;
  logic           nblkReg;
  logic [7:0]     toutCnt;
  logic [31:0]    rdDatReg;
  logic           failReg;
  logic           isDwbReq, isFslReq, timedOut, startReq;
  logic [3:0]     alignSel;
  logic [31:0]    alignRep, alignLoad;

  aemb_bus_align uAlign (
    .reqSiz    (req_siz),
    .reqAdrLo  (req_adr[1:0]),
    .reqDat    (req_dat),
    .reqSel    (alignSel),
    .reqDatRep (alignRep),
    .lodSiz    (sizReg),
    .lodAdrLo  (adrLoReg),
    .lodDat    (dwb_dat_i),
    .lodExt    (alignLoad)
  );

  // Next-state selection, timeout detection and the combinational stall.
  always_comb begin
    isDwbReq  = req_lod | req_str;
    isFslReq  = req_get | req_put;
    timedOut  = (state == FSL) & ~fsl_ack_i & nblkReg & (toutCnt <= 8'd1);
    stateNext = state;
    case (state)
      IDLE: begin
        if (req_vld & isDwbReq)      stateNext = DWB;
        else if (req_vld & isFslReq) stateNext = FSL;
      end
      DWB:  if (dwb_ack_i) stateNext = DONE;
      FSL:  if (fsl_ack_i | timedOut) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    startReq  = (state == IDLE) & (stateNext != IDLE);
    bus_stall = ((state == IDLE) & req_vld & (isDwbReq | isFslReq)) |
                (state == DWB) | (state == FSL);
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge gclk) begin
    if (grst) state <= IDLE;
    else      state <= stateNext;
  end

  // Capture request fields when leaving IDLE and run the non-blocking timeout.
  always_ff @(posedge gclk) begin
    if (grst) begin
      adrReg   <= '0;
      adrLoReg <= 2'd0;
      sizReg   <= 2'd0;
      selReg   <= 4'd0;
      datReg   <= 32'd0;
      fidReg   <= '0;
      wreReg   <= 1'b0;
      nblkReg  <= 1'b0;
      toutCnt  <= 8'd0;
    end else if (startReq) begin
      adrReg   <= {req_adr[DAW-1:2], 2'b00};
      adrLoReg <= req_adr[1:0];
      sizReg   <= req_siz;
      fidReg   <= req_fid;
      nblkReg  <= req_nblk;
      toutCnt  <= 8'(TOUT);
      if (stateNext == DWB) begin
        selReg <= alignSel;
        datReg <= alignRep;
        wreReg <= req_str;
      end else begin
        selReg <= 4'd0;
        datReg <= req_dat;
        wreReg <= req_put;
      end
    end else if ((state == FSL) && !fsl_ack_i && (toutCnt != 8'd0)) begin
      toutCnt <= toutCnt - 8'd1;
    end
  end

  // Return data and failure flag, captured on the completing cycle.
  always_ff @(posedge gclk) begin
    if (grst) begin
      rdDatReg <= 32'd0;
      failReg  <= 1'b0;
    end else begin
      failReg <= 1'b0;
      if ((state == DWB) && dwb_ack_i) begin
        rdDatReg <= alignLoad;
      end else if ((state == FSL) && fsl_ack_i) begin
        rdDatReg <= fsl_dat_i;
      end else if (timedOut) begin
        rdDatReg <= 32'd0;
        failReg  <= 1'b1;
      end
    end
  end

  assign dwb_stb_o = (state == DWB);
  assign dwb_wre_o = wreReg & (state == DWB);
  assign dwb_sel_o = selReg;
  assign dwb_adr_o = adrReg;
  assign dwb_dat_o = datReg;
  assign fsl_stb_o = (state == FSL);
  assign fsl_wre_o = wreReg & (state == FSL);
  assign fsl_tag_o = fidReg;
  assign fsl_dat_o = datReg;
  assign rd_vld    = (state == DONE);
  assign rd_dat    = rdDatReg;
  assign nblk_fail = failReg;

endmodule

// File: tb/tb_aemb_xbus_ctrl.sv
// Self-checking bench for aemb_xbus_ctrl: a per-transaction timing model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_aemb_xbus_ctrl;

  localparam int DAW  = 32;
  localparam int FSLN = 4;
  localparam int TOUT = 4;
  localparam int CHW  = 2;

  logic           gclk = 1'b0;
  logic           grst;
  logic           req_vld, req_lod, req_str, req_get, req_put, req_nblk;
  logic [CHW-1:0] req_fid;
  logic [1:0]     req_siz;
  logic [DAW-1:0] req_adr;
  logic [31:0]    req_dat;
  logic           dwb_stb_o, dwb_wre_o;
  logic [3:0]     dwb_sel_o;
  logic [DAW-1:0] dwb_adr_o;
  logic [31:0]    dwb_dat_o;
  logic           dwb_ack_i;
  logic [31:0]    dwb_dat_i;
  logic           fsl_stb_o, fsl_wre_o;
  logic [CHW-1:0] fsl_tag_o;
  logic [31:0]    fsl_dat_o;
  logic           fsl_ack_i;
  logic [31:0]    fsl_dat_i;
  logic           bus_stall, rd_vld, nblk_fail;
  logic [31:0]    rd_dat;

  int checks   = 0;
  int failures = 0;

  // Model of the transaction in flight
  bit          active  = 1'b0;
  bit          chkIdle = 1'b0;
  int          cyc, endCyc;
  bit          mIsDwb, mIsFsl, mWre, mFail, mChkRd;
  logic [3:0]  mSel;
  logic [31:0] mAdr, mDat, mRd;
  logic [1:0]  mFid;

  // Observations of the DUT for the literal checks
  int          obsDstb, obsFstb, obsRdVldCyc, obsRdCnt;
  logic [3:0]  obsSel;
  logic [1:0]  obsTag;
  logic        obsWre, obsFail;
  logic [31:0] obsRd;

  aemb_xbus_ctrl #(.DAW(DAW), .FSLN(FSLN), .TOUT(TOUT)) dut (
    .gclk(gclk), .grst(grst),
    .req_vld(req_vld), .req_lod(req_lod), .req_str(req_str), .req_get(req_get),
    .req_put(req_put), .req_nblk(req_nblk), .req_fid(req_fid), .req_siz(req_siz),
    .req_adr(req_adr), .req_dat(req_dat),
    .dwb_stb_o(dwb_stb_o), .dwb_wre_o(dwb_wre_o), .dwb_sel_o(dwb_sel_o),
    .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_ack_i(dwb_ack_i),
    .dwb_dat_i(dwb_dat_i),
    .fsl_stb_o(fsl_stb_o), .fsl_wre_o(fsl_wre_o), .fsl_tag_o(fsl_tag_o),
    .fsl_dat_o(fsl_dat_o), .fsl_ack_i(fsl_ack_i), .fsl_dat_i(fsl_dat_i),
    .bus_stall(bus_stall), .rd_vld(rd_vld), .rd_dat(rd_dat), .nblk_fail(nblk_fail)
  );

  always #5 gclk = ~gclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] modelSel(input logic [1:0] siz, input logic [31:0] adr);
    int lane;
    lane = int'(adr % 32'd4);
    if (siz == 2'd0) return 4'(1 << (3 - lane));
    if (siz == 2'd1) return (((adr / 32'd2) % 32'd2) == 32'd1) ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction

  function automatic logic [31:0] modelStore(input logic [1:0] siz, input logic [31:0] d);
    if (siz == 2'd0) return (d % 32'd256) * 32'h01010101;
    if (siz == 2'd1) return (d % 32'd65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] siz, input logic [31:0] adr,
                                            input logic [31:0] din);
    int lane;
    lane = int'(adr % 32'd4);
    if (siz == 2'd0) return (din >> (8 * (3 - lane))) % 32'd256;
    if (siz == 2'd1) return (din >> ((lane >= 2) ? 0 : 16)) % 32'd65536;
    return din;
  endfunction

  // Per-cycle comparison against the transaction model
  always @(negedge gclk) begin
    if (dwb_stb_o) begin obsDstb++; obsSel = dwb_sel_o; obsWre = dwb_wre_o; end
    if (fsl_stb_o) begin obsFstb++; obsTag = fsl_tag_o; obsWre = fsl_wre_o; end
    if (rd_vld) begin obsRdCnt++; obsRdVldCyc = cyc; obsRd = rd_dat; obsFail = nblk_fail; end
    if (active) begin
      checkOutput("bus_stall", 32'(bus_stall), 32'(cyc <= endCyc));
      checkOutput("dwb_stb_o", 32'(dwb_stb_o), 32'(mIsDwb && cyc >= 1 && cyc <= endCyc));
      checkOutput("fsl_stb_o", 32'(fsl_stb_o), 32'(mIsFsl && cyc >= 1 && cyc <= endCyc));
      checkOutput("rd_vld", 32'(rd_vld), 32'(cyc == endCyc + 1));
      if (mIsDwb && cyc >= 1 && cyc <= endCyc) begin
        checkOutput("dwb_sel_o", 32'(dwb_sel_o), 32'(mSel));
        checkOutput("dwb_adr_o", dwb_adr_o, mAdr);
        checkOutput("dwb_wre_o", 32'(dwb_wre_o), 32'(mWre));
        if (mWre) checkOutput("dwb_dat_o", dwb_dat_o, mDat);
      end
      if (mIsFsl && cyc >= 1 && cyc <= endCyc) begin
        checkOutput("fsl_tag_o", 32'(fsl_tag_o), 32'(mFid));
        checkOutput("fsl_wre_o", 32'(fsl_wre_o), 32'(mWre));
        if (mWre) checkOutput("fsl_dat_o", fsl_dat_o, mDat);
      end
      if (cyc == endCyc + 1) begin
        checkOutput("nblk_fail", 32'(nblk_fail), 32'(mFail));
        if (mChkRd) checkOutput("rd_dat", rd_dat, mRd);
      end
    end else if (chkIdle) begin
      checkOutput("idle_stall", 32'(bus_stall), 32'd0);
      checkOutput("idle_dwb_stb", 32'(dwb_stb_o), 32'd0);
      checkOutput("idle_fsl_stb", 32'(fsl_stb_o), 32'd0);
      checkOutput("idle_rd_vld", 32'(rd_vld), 32'd0);
    end
  end

  task automatic clearReq();
    req_vld = 0; req_lod = 0; req_str = 0; req_get = 0; req_put = 0; req_nblk = 0;
    req_fid = '0; req_siz = 2'd0; req_adr = '0; req_dat = '0;
  endtask

  task automatic resetObs();
    obsDstb = 0; obsFstb = 0; obsRdVldCyc = -1; obsRdCnt = 0;
    obsSel = 4'd0; obsTag = 2'd0; obsWre = 1'b0; obsFail = 1'b0; obsRd = 32'd0;
  endtask

  // One complete transaction; ackAt is the cycle the ack is offered (0 = never)
  task automatic applyStimulus(input bit lod, input bit str, input bit get, input bit put,
                               input bit nblk, input logic [1:0] fid, input logic [1:0] siz,
                               input logic [31:0] adr, input logic [31:0] dat,
                               input logic [31:0] rdData, input int ackAt);
    bit ack;
    @(posedge gclk); #1;
    mIsDwb = lod | str;
    mIsFsl = !mIsDwb && (get || put);
    mWre   = mIsDwb ? str : put;
    mFid   = fid;
    mSel   = modelSel(siz, adr);
    mAdr   = adr - (adr % 32'd4);
    mDat   = mIsDwb ? modelStore(siz, dat) : dat;
    if (mIsFsl && nblk && !(ackAt >= 1 && ackAt <= TOUT)) begin
      endCyc = TOUT; mFail = 1'b1; mRd = 32'd0;
    end else begin
      endCyc = ackAt; mFail = 1'b0; mRd = mIsDwb ? modelLoad(siz, adr, rdData) : rdData;
    end
    mChkRd = mFail || (mIsDwb ? !str : !put);
    resetObs();
    req_vld = 1; req_lod = lod; req_str = str; req_get = get; req_put = put;
    req_nblk = nblk; req_fid = fid; req_siz = siz; req_adr = adr; req_dat = dat;
    cyc = 0; active = 1'b1;
    for (int c = 1; c <= endCyc + 1; c++) begin
      @(posedge gclk); #1;
      cyc = c;
      ack = (c == ackAt) && (c <= endCyc);
      dwb_ack_i = mIsDwb & ack;
      fsl_ack_i = mIsFsl & ack;
      dwb_dat_i = ack ? rdData : 32'hA5A50F0F;
      fsl_dat_i = ack ? rdData : 32'h0F0FA5A5;
    end
    @(posedge gclk); #1;
    active = 1'b0;
    clearReq();
    dwb_ack_i = 0; fsl_ack_i = 0;
  endtask

  initial begin
    grst = 1; clearReq();
    dwb_ack_i = 0; fsl_ack_i = 0; dwb_dat_i = 32'd0; fsl_dat_i = 32'd0;
    cyc = 0; endCyc = 0; resetObs();
    repeat (3) @(posedge gclk);
    #1 grst = 0;
    checkOutput("rst_dwb_stb", 32'(dwb_stb_o), 32'd0);
    checkOutput("rst_fsl_stb", 32'(fsl_stb_o), 32'd0);
    checkOutput("rst_rd_vld", 32'(rd_vld), 32'd0);
    checkOutput("rst_stall", 32'(bus_stall), 32'd0);
    checkOutput("rst_rd_dat", rd_dat, 32'd0);
    checkOutput("rst_sel", 32'(dwb_sel_o), 32'd0);
    checkOutput("rst_adr", dwb_adr_o, 32'd0);
    checkOutput("rst_fail", 32'(nblk_fail), 32'd0);
    chkIdle = 1'b1;

    // Word store, ack on cycle 3
    applyStimulus(0, 1, 0, 0, 0, 2'd0, 2'd2, 32'h104, 32'hDEADBEEF, 32'd0, 3);
    checkOutput("wst_stb_cycles", 32'(obsDstb), 32'd3);
    checkOutput("wst_sel", 32'(obsSel), 32'hF);
    checkOutput("wst_wre", 32'(obsWre), 32'd1);
    checkOutput("wst_rdvld_cycle", 32'(obsRdVldCyc), 32'd4);

    // Byte and half loads from the same word
    applyStimulus(1, 0, 0, 0, 0, 2'd0, 2'd0, 32'h13, 32'd0, 32'h11223344, 2);
    checkOutput("bld_sel", 32'(obsSel), 32'h1);
    checkOutput("bld_rd", obsRd, 32'h44);
    applyStimulus(1, 0, 0, 0, 0, 2'd0, 2'd1, 32'h12, 32'd0, 32'h11223344, 1);
    checkOutput("hld_sel", 32'(obsSel), 32'h3);
    checkOutput("hld_rd", obsRd, 32'h3344);
    applyStimulus(1, 0, 0, 0, 0, 2'd0, 2'd1, 32'h10, 32'd0, 32'h11223344, 1);
    checkOutput("hld_hi_rd", obsRd, 32'h1122);

    // Byte/half stores, size 3 load
    applyStimulus(0, 1, 0, 0, 0, 2'd0, 2'd0, 32'h21, 32'h000000A5, 32'd0, 1);
    checkOutput("bst_sel", 32'(obsSel), 32'h4);
    applyStimulus(0, 1, 0, 0, 0, 2'd0, 2'd1, 32'h30, 32'h00001234, 32'd0, 2);
    applyStimulus(1, 0, 0, 0, 0, 2'd0, 2'd3, 32'h7, 32'd0, 32'h89ABCDEF, 1);
    checkOutput("siz3_sel", 32'(obsSel), 32'hF);
    checkOutput("siz3_rd", obsRd, 32'h89ABCDEF);

    // Non-blocking get, no ack: timeout
    applyStimulus(0, 0, 1, 0, 1, 2'd2, 2'd2, 32'd0, 32'd0, 32'hCAFEF00D, 0);
    checkOutput("nget_stb_cycles", 32'(obsFstb), 32'd4);
    checkOutput("nget_tag", 32'(obsTag), 32'd2);
    checkOutput("nget_fail", 32'(obsFail), 32'd1);
    checkOutput("nget_rd", obsRd, 32'd0);

    // Non-blocking get, ack on the expiry cycle wins
    applyStimulus(0, 0, 1, 0, 1, 2'd2, 2'd2, 32'd0, 32'd0, 32'hCAFEF00D, 4);
    checkOutput("ngetack_stb_cycles", 32'(obsFstb), 32'd4);
    checkOutput("ngetack_fail", 32'(obsFail), 32'd0);
    checkOutput("ngetack_rd", obsRd, 32'hCAFEF00D);

    // Blocking put, long wait
    applyStimulus(0, 0, 0, 1, 0, 2'd3, 2'd2, 32'd0, 32'h000055AA, 32'd0, 20);
    checkOutput("put_stb_cycles", 32'(obsFstb), 32'd20);
    checkOutput("put_wre", 32'(obsWre), 32'd1);
    checkOutput("put_fail", 32'(obsFail), 32'd0);

    // Non-blocking put whose ack would come too late
    applyStimulus(0, 0, 0, 1, 1, 2'd1, 2'd2, 32'd0, 32'h0BADF00D, 32'd0, 5);
    checkOutput("nput_fail", 32'(obsFail), 32'd1);

    // Priority: DWB over FSL, store over load, put over get
    applyStimulus(1, 0, 1, 0, 0, 2'd1, 2'd2, 32'h200, 32'd0, 32'h01020304, 2);
    checkOutput("prio_fsl_stb", 32'(obsFstb), 32'd0);
    checkOutput("prio_dwb_stb", 32'(obsDstb), 32'd2);
    applyStimulus(1, 1, 0, 0, 0, 2'd0, 2'd2, 32'h40, 32'h76543210, 32'd0, 1);
    checkOutput("prio_str_wre", 32'(obsWre), 32'd1);
    applyStimulus(0, 0, 1, 1, 0, 2'd1, 2'd2, 32'd0, 32'h13579BDF, 32'd0, 1);
    checkOutput("prio_put_wre", 32'(obsWre), 32'd1);

    // Reset in the middle of a load, then an ack that arrives too late
    @(posedge gclk); #1;
    mIsDwb = 1; mIsFsl = 0; mWre = 0; mSel = 4'hF; mAdr = 32'h80; mFail = 0; mChkRd = 0;
    mFid = 2'd0; mDat = 32'd0; mRd = 32'd0; endCyc = 100;
    resetObs();
    req_vld = 1; req_lod = 1; req_siz = 2'd2; req_adr = 32'h80;
    cyc = 0; active = 1'b1;
    @(posedge gclk); #1 cyc = 1;
    @(posedge gclk); #1 cyc = 2;
    grst = 1; clearReq();
    @(posedge gclk); #1;
    active = 1'b0; grst = 0;
    dwb_ack_i = 1; dwb_dat_i = 32'h12345678;
    @(posedge gclk); #1;
    @(posedge gclk); #1 dwb_ack_i = 0;
    @(posedge gclk); #1;
    checkOutput("grst_rd_cnt", 32'(obsRdCnt), 32'd0);
    checkOutput("grst_rd_dat", rd_dat, 32'd0);
    checkOutput("grst_sel", 32'(dwb_sel_o), 32'd0);
    checkOutput("grst_adr", dwb_adr_o, 32'd0);
    checkOutput("grst_stb_cycles", 32'(obsDstb), 32'd2);

    repeat (2) @(posedge gclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
